// File: rtl/i2s_cap_pkg.sv
// Shared widths and output-state encoding for the I2S capture path.
// Pure declarations; no logic, no latency, no flow control.
package i2s_cap_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int DATA_W    = 16;
    localparam int SLOT_BITS = 32;

    typedef enum logic [1:0] {
        EMPTY,
        OFFER,
        HOLD
    } out_state_t;

endpackage

// File: rtl/i2s_rx.sv
// Purpose: synchronise raw I2S lines and capture the 24-bit left-channel word.
// Latency: sample_valid within 4 sys_clk cycles of the sck rise carrying bit 23.
// Backpressure: none; every complete left word is strobed out unconditionally.
module i2s_rx
    import i2s_cap_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                i2s_sck,
    input  logic                i2s_ws,
    input  logic                i2s_sd,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    localparam int CNT_W = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

    logic [1:0]          sck_sync;
    logic [1:0]          ws_sync;
    logic [1:0]          sd_sync;
    logic                sck_d;
    logic                ws_prev;
    logic                active;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] shreg;
    logic                sck_rise;

    assign sck_rise = sck_sync[1] & ~sck_d;

    // ws_prev resets to 0 so a reset inside a left slot cannot fake a 1->0
    // transition; capture resumes only at the next real slot start.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_sync     <= '0;
            ws_sync      <= '0;
            sd_sync      <= '0;
            sck_d        <= 1'b0;
            ws_prev      <= 1'b0;
            active       <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sck_sync     <= {sck_sync[0], i2s_sck};
            ws_sync      <= {ws_sync[0], i2s_ws};
            sd_sync      <= {sd_sync[0], i2s_sd};
            sck_d        <= sck_sync[1];
            sample_valid <= 1'b0;
            if (sck_rise) begin
                ws_prev <= ws_sync[1];
                if (ws_sync[1] != ws_prev) begin
                    // 1->0 opens the left slot; 0->1 abandons any partial word
                    active  <= ~ws_sync[1];
                    bit_cnt <= '0;
                end else if (active) begin
                    shreg <= {shreg[SAMPLE_W-2:0], sd_sync[1]};
                    if (bit_cnt == LAST_BIT) begin
                        sample       <= {shreg[SAMPLE_W-2:0], sd_sync[1]};
                        sample_valid <= 1'b1;
                        active       <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/i2s_peak_meter.sv
// Purpose: windowed peak |sample| of the left I2S channel, offered to a UART printer.
// Latency: data/uart_ena valid 2 cycles after the window's final sample strobe.
// Backpressure: data frozen while offered and for HOLD_CYCLES after uart_ready; one-deep newest-wins pending, drops flag overrun.
module i2s_peak_meter
    import i2s_cap_pkg::*;
#(
    parameter int WINDOW_LOG2 = 12,
    parameter int HOLD_CYCLES = 32768
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                i2s_sck,
    input  logic                i2s_ws,
    input  logic                i2s_sd,
    input  logic                uart_ready,
    output logic [DATA_W-1:0]   data,
    output logic                uart_ena,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                overrun
);

    localparam int ABS_W  = SAMPLE_W - 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST  = '1;
    localparam logic [SAMPLE_W-1:0]    NEG_FULL  = {1'b1, {(SAMPLE_W-1){1'b0}}};

    i2s_rx u_rx (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    logic [SAMPLE_W-1:0]    neg_sample;
    logic [ABS_W-1:0]       abs_val;
    logic [ABS_W-1:0]       peak;
    logic [ABS_W-1:0]       peak_next;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic                   res_vld;
    logic [DATA_W-1:0]      res_dat;

    assign neg_sample = ~sample + 1'b1;

    // -full scale has no positive 24-bit twin, so it clamps to the 23-bit max
    always_comb begin
        abs_val = sample[ABS_W-1:0];
        if (sample[SAMPLE_W-1]) begin
            abs_val = (sample == NEG_FULL) ? '1 : neg_sample[ABS_W-1:0];
        end
    end

    assign peak_next = (abs_val > peak) ? abs_val : peak;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            peak    <= '0;
            win_cnt <= '0;
            res_vld <= 1'b0;
            res_dat <= '0;
        end else begin
            res_vld <= 1'b0;
            if (sample_valid) begin
                if (win_cnt == WIN_LAST) begin
                    res_vld <= 1'b1;
                    res_dat <= peak_next[ABS_W-1 -: DATA_W];
                    peak    <= '0;
                    win_cnt <= '0;
                end else begin
                    peak    <= peak_next;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

    out_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              pend_vld;
    logic [DATA_W-1:0] pend_dat;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= EMPTY;
            data     <= '0;
            uart_ena <= 1'b0;
            hold_cnt <= '0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (res_vld) begin
                        data     <= res_dat;
                        uart_ena <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (res_vld) begin
                        pend_dat <= res_dat;
                        pend_vld <= 1'b1;
                        if (pend_vld) overrun <= 1'b1;
                    end
                    if (uart_ready) begin
                        uart_ena <= 1'b0;
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        // a result arriving at expiry is fresher than pending
                        if (res_vld) begin
                            data     <= res_dat;
                            uart_ena <= 1'b1;
                            pend_vld <= 1'b0;
                            if (pend_vld) overrun <= 1'b1;
                            state    <= OFFER;
                        end else if (pend_vld) begin
                            data     <= pend_dat;
                            uart_ena <= 1'b1;
                            pend_vld <= 1'b0;
                            state    <= OFFER;
                        end else begin
                            state    <= EMPTY;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                        if (res_vld) begin
                            pend_dat <= res_dat;
                            pend_vld <= 1'b1;
                            if (pend_vld) overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= EMPTY;
                    uart_ena <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_peak_meter.sv
// Directed bench for i2s_peak_meter with a 4-sample window and 16-cycle hold.
module tb_i2s_peak_meter;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        i2s_sck    = 1'b0;
    logic        i2s_ws     = 1'b1;
    logic        i2s_sd     = 1'b0;
    logic        uart_ready = 1'b0;
    logic [15:0] data;
    logic        uart_ena;
    logic [23:0] sample;
    logic        sample_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    i2s_peak_meter #(.WINDOW_LOG2(2), .HOLD_CYCLES(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .uart_ready   (uart_ready),
        .data         (data),
        .uart_ena     (uart_ena),
        .sample       (sample),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    int   ncyc     = 0;
    int   sv_cnt   = 0;
    int   last_sv  = 0;
    int   ena_rise = 0;
    logic ena_q    = 1'b0;

    always @(negedge sys_clk) begin
        ncyc  <= ncyc + 1;
        ena_q <= uart_ena;
        if (sample_valid) begin
            sv_cnt  <= sv_cnt + 1;
            last_sv <= ncyc;
        end
        if (uart_ena && !ena_q) ena_rise <= ncyc;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, actual time %0t required < 3ms", $time);
        $fatal(1);
    end

    task automatic i2s_bit(input logic ws_v, input logic sd_v);
        i2s_ws = ws_v;
        i2s_sd = sd_v;
        #40 i2s_sck = 1'b1;
        #40 i2s_sck = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] v, input int nbits);
        repeat (4) i2s_bit(1'b1, 1'b0);
        i2s_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) i2s_bit(1'b0, v[23-i]);
        if (nbits == 24) repeat (3) i2s_bit(1'b0, 1'b0);
    endtask

    task automatic send_window(input logic [23:0] a, input logic [23:0] b,
                               input logic [23:0] c, input logic [23:0] d);
        send_frame(a, 24);
        send_frame(b, 24);
        send_frame(c, 24);
        send_frame(d, 24);
    endtask

    task automatic wait_ena(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk);
            if (uart_ena) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic pulse_ready();
        @(negedge sys_clk);
        uart_ready = 1'b1;
        @(negedge sys_clk);
        uart_ready = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (data !== 16'h0)     begin errors++; $display("FAIL reset_data: got %h want 0000", data); end
        checks++; if (uart_ena !== 1'b0)  begin errors++; $display("FAIL reset_ena: got %b want 0", uart_ena); end
        checks++; if (sample !== 24'h0)   begin errors++; $display("FAIL reset_sample: got %h want 000000", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b want 0", sample_valid); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_constant();
        int sv0;
        bit ok;
        bit bad;
        sv0 = sv_cnt;
        send_window(24'h123456, 24'h123456, 24'h123456, 24'h123456);
        wait_ena(ok);
        checks++; if (!ok) begin errors++; $display("FAIL const_timeout: uart_ena got 0 want 1"); end
        checks++; if (data !== 16'h2468) begin errors++; $display("FAIL const_data: got %h want 2468", data); end
        checks++; if (ena_rise - last_sv !== 2) begin errors++; $display("FAIL const_latency: got %0d want 2", ena_rise - last_sv); end
        checks++; if (sv_cnt - sv0 !== 4) begin errors++; $display("FAIL const_strobes: got %0d want 4", sv_cnt - sv0); end
        checks++; if (sample !== 24'h123456) begin errors++; $display("FAIL const_sample: got %h want 123456", sample); end
        pulse_ready();
        checks++; if (uart_ena !== 1'b0) begin errors++; $display("FAIL const_ena_fall: got %b want 0", uart_ena); end
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge sys_clk);
            if (uart_ena !== 1'b0 || data !== 16'h2468) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL const_hold: data/ena changed in hold, got %h/%b want 2468/0", data, uart_ena); end
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic test_neg_full();
        bit ok;
        send_window(24'h800000, 24'h800000, 24'h800000, 24'h800000);
        wait_ena(ok);
        checks++; if (!ok) begin errors++; $display("FAIL negfs_timeout: uart_ena got 0 want 1"); end
        checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL negfs_data: got %h want ffff", data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL negfs_overrun: got %b want 0", overrun); end
        checks++; if (sample !== 24'h800000) begin errors++; $display("FAIL negfs_sample: got %h want 800000", sample); end
        pulse_ready();
        repeat (25) @(negedge sys_clk);
    endtask

    task automatic test_mixed();
        bit ok;
        send_window(24'h000100, 24'hFFFF00, 24'h001000, 24'h000080);
        wait_ena(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mixed_timeout: uart_ena got 0 want 1"); end
        checks++; if (data !== 16'h0020) begin errors++; $display("FAIL mixed_data: got %h want 0020", data); end
        pulse_ready();
        repeat (25) @(negedge sys_clk);
        send_window(24'h0, 24'h0, 24'h0, 24'h0);
        wait_ena(ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: uart_ena got 0 want 1"); end
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL zero_data: got %h want 0000", data); end
        pulse_ready();
        repeat (25) @(negedge sys_clk);
    endtask

    task automatic test_truncated();
        int sv0;
        bit ok;
        sv0 = sv_cnt;
        send_frame(24'h7FFFFF, 10);
        send_frame(24'h000400, 24);
        send_frame(24'h000400, 24);
        send_frame(24'h000400, 24);
        repeat (5) @(negedge sys_clk);
        checks++; if (sv_cnt - sv0 !== 3) begin errors++; $display("FAIL trunc_strobes: got %0d want 3", sv_cnt - sv0); end
        checks++; if (uart_ena !== 1'b0) begin errors++; $display("FAIL trunc_early_result: uart_ena got %b want 0", uart_ena); end
        checks++; if (sample !== 24'h000400) begin errors++; $display("FAIL trunc_sample: got %h want 000400", sample); end
        send_frame(24'h000800, 24);
        wait_ena(ok);
        checks++; if (!ok) begin errors++; $display("FAIL trunc_timeout: uart_ena got 0 want 1"); end
        checks++; if (data !== 16'h0010) begin errors++; $display("FAIL trunc_data: got %h want 0010", data); end
        pulse_ready();
        repeat (25) @(negedge sys_clk);
    endtask

    task automatic test_handshake_overrun();
        bit ok;
        bit bad;
        int rise_k;
        send_window(24'h010000, 24'h010000, 24'h010000, 24'h010000);
        wait_ena(ok);
        checks++; if (!ok || data !== 16'h0200) begin errors++; $display("FAIL hs_first: got %h/%b want 0200/1", data, ok); end
        send_window(24'h020000, 24'h020000, 24'h020000, 24'h020000);
        repeat (10) @(negedge sys_clk);
        checks++; if (uart_ena !== 1'b1 || data !== 16'h0200) begin errors++; $display("FAIL hs_second_stable: got %h/%b want 0200/1", data, uart_ena); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hs_overrun_early: got %b want 0", overrun); end
        send_window(24'h030000, 24'h030000, 24'h030000, 24'h030000);
        repeat (10) @(negedge sys_clk);
        checks++; if (uart_ena !== 1'b1 || data !== 16'h0200) begin errors++; $display("FAIL hs_third_stable: got %h/%b want 0200/1", data, uart_ena); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL hs_overrun: got %b want 1", overrun); end
        pulse_ready();
        checks++; if (uart_ena !== 1'b0) begin errors++; $display("FAIL hs_ena_fall: got %b want 0", uart_ena); end
        rise_k = -1;
        bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            if (uart_ena) begin
                rise_k = k;
                break;
            end
            if (data !== 16'h0200) bad = 1'b1;
        end
        checks++; if (rise_k !== 16) begin errors++; $display("FAIL hs_reoffer_delay: got %0d want 16", rise_k); end
        checks++; if (bad) begin errors++; $display("FAIL hs_hold_data: data changed during hold, want 0200"); end
        checks++; if (data !== 16'h0600) begin errors++; $display("FAIL hs_pending_data: got %h want 0600", data); end
        pulse_ready();
        repeat (25) @(negedge sys_clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL hs_overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_slot();
        int sv0;
        repeat (4) i2s_bit(1'b1, 1'b0);
        i2s_bit(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) i2s_bit(1'b0, i[0]);
        sys_rst_n = 1'b0;
        #1;
        checks++; if (data !== 16'h0 || uart_ena !== 1'b0) begin errors++; $display("FAIL rst_slot_out: got %h/%b want 0000/0", data, uart_ena); end
        checks++; if (sample !== 24'h0 || sample_valid !== 1'b0) begin errors++; $display("FAIL rst_slot_sample: got %h/%b want 000000/0", sample, sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_slot_overrun: got %b want 0", overrun); end
        #29 sys_rst_n = 1'b1;
        sv0 = sv_cnt;
        for (int i = 0; i < 15; i++) i2s_bit(1'b0, 1'b1);
        repeat (4) i2s_bit(1'b1, 1'b0);
        checks++; if (sv_cnt !== sv0 || sample !== 24'h0) begin errors++; $display("FAIL rst_slot_nocapture: strobes %0d sample %h want 0 000000", sv_cnt - sv0, sample); end
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        send_window(24'h000080, 24'h000080, 24'h000080, 24'h000080);
        wait_ena(ok);
        checks++; if (!ok || data !== 16'h0001) begin errors++; $display("FAIL rsthold_pre: got %h/%b want 0001/1", data, ok); end
        pulse_ready();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++; if (data !== 16'h0 || uart_ena !== 1'b0) begin errors++; $display("FAIL rsthold_out: got %h/%b want 0000/0", data, uart_ena); end
        checks++; if (sample !== 24'h0 || overrun !== 1'b0) begin errors++; $display("FAIL rsthold_state: got %h/%b want 000000/0", sample, overrun); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        checks++; if (uart_ena !== 1'b0) begin errors++; $display("FAIL rsthold_idle: got %b want 0", uart_ena); end
        send_window(24'h0ABCDE, 24'h0ABCDE, 24'h0ABCDE, 24'h0ABCDE);
        wait_ena(ok);
        checks++; if (!ok || data !== 16'h1579) begin errors++; $display("FAIL rsthold_window: got %h/%b want 1579/1", data, ok); end
        checks++; if (ena_rise - last_sv !== 2) begin errors++; $display("FAIL rsthold_latency: got %0d want 2", ena_rise - last_sv); end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_neg_full();
        test_mixed();
        test_truncated();
        test_handshake_overrun();
        test_reset_mid_slot();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_peak_meter.md
# i2s_peak_meter

Front end of the capture path. Deserialises a Philips-format I2S microphone stream (left channel, 24-bit) in the `sys_clk` domain and tracks the peak absolute amplitude over a window of samples. Each window result is presented as a 16-bit unsigned value to the downstream UART decimal printer through a `uart_ena`/`uart_ready` handshake. The presented value is held stable for the whole transmission.

## Interface
- `WINDOW_LOG2`, default 12: window length is 2^WINDOW_LOG2 samples.
- `HOLD_CYCLES`, default 32768: number of `sys_clk` cycles `data` stays frozen after `uart_ready`. Covers 6 UART frames at 115200 baud with a 50 MHz clock.
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `i2s_sck`  in  1  I2S bit clock, asynchronous to `sys_clk`.
- `i2s_ws`  in  1  I2S word select (0 = left), asynchronous.
- `i2s_sd`  in  1  I2S serial data, asynchronous.
- `uart_ready`  in  1  one-cycle pulse from the printer: `data` was accepted.
- `data`  out  16  peak value for the printer.
- `uart_ena`  out  1  `data` is valid and not yet accepted.
- `sample`  out  24  last captured left sample, two's complement.
- `sample_valid`  out  1  one-cycle strobe, `sample` updated.
- `overrun`  out  1  sticky flag: a window result was dropped unsent.

## Operation
- **Synchronisation:** 2-FF synchronisers on `sck`, `ws` and `sd`. An sck rising edge is detected on the synchronised signal. Requires f_sys ≥ 6·f_sck.
- **Slot capture:**
  - At each sck rise, `ws` is sampled.
  - A 1→0 `ws` transition starts the left slot. The bit at the next sck rise is the MSB (one-bit delay).
  - 24 bits are shifted in MSB-first. Slot bits 24..31 and the right channel are ignored.
  - After the 24th bit, `sample` is loaded and `sample_valid` pulses.
  - If `ws` changes before 24 bits are collected, the partial word is discarded: no strobe, no window update.
- **Absolute value:** |sample| is saturated to 23 bits, so 0x800000 → 0x7FFFFF.
- **Peak window:**
  - `peak` = max(`peak`, abs) on each strobe.
  - On the 2^WINDOW_LOG2-th strobe, result = max(`peak`, abs) is computed, `peak` clears to 0 and the sample counter wraps to 0.
  - Output value = result[22:7].
- **Output FSM:**
  - EMPTY: `uart_ena` = 0. A result loads `data` → OFFER.
  - OFFER: `uart_ena` = 1, `data` frozen. A result goes to the pending register. On `uart_ready` → HOLD, and the hold counter loads HOLD_CYCLES-1.
  - HOLD: `uart_ena` = 0, `data` frozen, counter decrements. A result goes to pending. At counter = 0: if pending is valid, load `data` from pending, clear pending, → OFFER; otherwise → EMPTY.
- **Pending register:** one-deep, newest wins. Overwriting a valid pending entry sets `overrun`.
- **Simultaneous events:**
  - HOLD expiry and a new result in the same cycle: the new result loads `data` directly and the state goes to OFFER. A valid pending entry is dropped and sets `overrun`.
  - `uart_ready` outside OFFER is ignored.
- **`overrun`** clears only on reset.

## Timing
- **Reset values:** `data` = 0, `uart_ena` = 0, `sample` = 0, `sample_valid` = 0, `overrun` = 0. State = EMPTY; pending, peak and all counters = 0.
- **Reset mid-slot or mid-HOLD:** everything is discarded. Capture restarts at the next `ws` 1→0 transition.
- **`sample_valid` latency:** at most 4 `sys_clk` cycles after the raw sck rise carrying slot bit 23.
- **Window result:** registered 1 cycle after the final `sample_valid`.
- **From EMPTY:** `data` and `uart_ena` update in the following cycle, i.e. 2 cycles after the final strobe.
- **After `uart_ready` (cycle t):** `uart_ena` = 0 from t+1. `data` is unchanged through t+HOLD_CYCLES. The earliest new `uart_ena` is at t+HOLD_CYCLES+1.
- **`data`** never changes while `uart_ena` = 1 or the state is HOLD, except at the HOLD→OFFER transition.

## Structure
- **Package `i2s_cap_pkg`:**
  - `SAMPLE_W` = 24, `DATA_W` = 16, `SLOT_BITS` = 32.
  - Output FSM state type: EMPTY, OFFER, HOLD.
- **Sub-module `i2s_rx`:** synchronisers, edge detect, slot capture. Outputs `sample`/`sample_valid`.
- **Top level:** abs/saturation, window counter, peak, pending register, output FSM, hold counter.

## Test plan
- **Constant sample:** WINDOW_LOG2 = 2, four slots of 0x123456 → `data` = 0x2468; `uart_ena` rises 2 cycles after the 4th strobe.
- **Negative full scale:** four slots of 0x800000 → `data` = 0xFFFF (saturation), `overrun` = 0.
- **Mixed slots:** 0x000100, 0xFFFF00, 0x001000, 0x000080 → `data` = 0x0020. The next window, all 0, gives `data` = 0x0000.
- **Handshake and overrun:** HOLD_CYCLES = 16, `uart_ready` held low across 3 windows → `uart_ena` stays 1, first value stable, `overrun` = 1. Then pulse `uart_ready` → `uart_ena` falls the next cycle and rises 16 cycles later with the third window's value.
- **Truncated slot:** `ws` toggles after 10 bits → no `sample_valid`, window count unchanged; the next full slot is captured correctly.
- **Reset:** assert reset mid-slot and again in HOLD → all outputs read their reset values. The first full window after release is reported correctly.
